// File: rtl/lpc_pkg.sv
// Shared encodings for the LPC host: FSM states, cycle-type and SYNC nibbles.
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_CYC, ST_ADDR, ST_WDATA, ST_TAR,
        ST_SYNC, ST_RDATA, ST_TAREND, ST_ABORT, ST_RESP
    } lpc_state_t;

    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;
    localparam logic [3:0] SYNC_NONE  = 4'b1111;

    // Address nibble i of a 16-bit I/O address, most significant first.
    function automatic logic [3:0] addr_nib(input logic [15:0] a, input logic [1:0] i);
        case (i)
            2'd0:    return a[15:12];
            2'd1:    return a[11:8];
            2'd2:    return a[7:4];
            default: return a[3:0];
        endcase
    endfunction

endpackage

// File: rtl/lpc_host_io_sync_tracker.sv
// Classifies the SYNC nibble each clock and tracks no-response and total-wait limits.
module lpc_sync_tracker
    import lpc_pkg::*;
#(
    parameter int NO_RESP_CLKS = 3,
    parameter int SYNC_TIMEOUT = 32
) (
    input  logic       lpc_clock,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] nibble,
    output logic       done,
    output logic       err,
    output logic       abort
);
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int NW = $clog2(NO_RESP_CLKS + 1);

    logic [TW-1:0] total_cnt;
    logic [NW-1:0] none_cnt;
    logic          last_total;

    // Counts include the clock being classified, so limits trip on the Nth sample.
    assign last_total = (total_cnt == TW'(SYNC_TIMEOUT - 1));

    always_comb begin
        done  = 1'b0;
        err   = 1'b0;
        abort = 1'b0;
        if (en) begin
            case (nibble)
                SYNC_READY:            done = 1'b1;
                SYNC_ERROR:            begin done = 1'b1; err = 1'b1; end
                SYNC_SHORT, SYNC_LONG: abort = last_total;
                SYNC_NONE:             abort = last_total || (none_cnt == NW'(NO_RESP_CLKS - 1));
                default:               abort = 1'b1;
            endcase
        end
    end

    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            total_cnt <= '0;
            none_cnt  <= '0;
        end else if (!en) begin
            total_cnt <= '0;
            none_cnt  <= '0;
        end else begin
            total_cnt <= total_cnt + 1'b1;
            none_cnt  <= (nibble == SYNC_NONE) ? none_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/lpc_host_io.sv
// LPC 1.1 host issuing single-byte I/O read/write cycles from a valid/ready request port.
module lpc_host_io
    import lpc_pkg::*;
#(
    parameter int NO_RESP_CLKS = 3,
    parameter int SYNC_TIMEOUT = 32,
    parameter int ABORT_CLKS   = 4
) (
    input  logic        lpc_clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic        lpc_frame,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in
);
    localparam int AW = $clog2(ABORT_CLKS + 1);

    lpc_state_t    state;
    logic [1:0]    cnt;
    logic [AW-1:0] abort_cnt;
    logic          cyc_write, err;
    logic [15:0]   cyc_addr;
    logic [7:0]    cyc_wdata;
    logic [3:0]    rdata_lo;
    logic          sync_done, sync_err, sync_abort;

    lpc_sync_tracker #(.NO_RESP_CLKS(NO_RESP_CLKS), .SYNC_TIMEOUT(SYNC_TIMEOUT)) u_sync (
        .lpc_clock (lpc_clock),
        .reset     (reset),
        .en        (state == ST_SYNC),
        .nibble    (lpc_ad_in),
        .done      (sync_done),
        .err       (sync_err),
        .abort     (sync_abort)
    );

    // Bus outputs are loaded on the transition into each state so they are flop outputs.
    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            abort_cnt  <= '0;
            cyc_write  <= 1'b0;
            cyc_addr   <= '0;
            cyc_wdata  <= '0;
            err        <= 1'b0;
            rdata_lo   <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            lpc_frame  <= 1'b1;
            lpc_ad_oe  <= 1'b0;
            lpc_ad_out <= 4'hF;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid && req_ready) begin
                    cyc_write  <= req_write;
                    cyc_addr   <= req_addr;
                    cyc_wdata  <= req_wdata;
                    err        <= 1'b0;
                    req_ready  <= 1'b0;
                    lpc_frame  <= 1'b0;
                    lpc_ad_oe  <= 1'b1;
                    lpc_ad_out <= 4'h0;
                    state      <= ST_START;
                end
                ST_START: begin
                    lpc_frame  <= 1'b1;
                    lpc_ad_out <= cyc_write ? CYC_IO_WR : CYC_IO_RD;
                    state      <= ST_CYC;
                end
                ST_CYC: begin
                    cnt        <= '0;
                    lpc_ad_out <= addr_nib(cyc_addr, 2'd0);
                    state      <= ST_ADDR;
                end
                ST_ADDR: begin
                    cnt <= cnt + 2'd1;
                    if (cnt != 2'd3) begin
                        lpc_ad_out <= addr_nib(cyc_addr, cnt + 2'd1);
                    end else if (cyc_write) begin
                        lpc_ad_out <= cyc_wdata[3:0];
                        state      <= ST_WDATA;
                    end else begin
                        lpc_ad_out <= 4'hF;
                        state      <= ST_TAR;
                    end
                end
                ST_WDATA: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd0) begin
                        lpc_ad_out <= cyc_wdata[7:4];
                    end else begin
                        cnt        <= '0;
                        lpc_ad_out <= 4'hF;
                        state      <= ST_TAR;
                    end
                end
                ST_TAR: begin
                    cnt       <= cnt + 2'd1;
                    lpc_ad_oe <= 1'b0;
                    if (cnt == 2'd1) begin
                        cnt   <= '0;
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (sync_abort) begin
                        err        <= 1'b1;
                        abort_cnt  <= '0;
                        lpc_frame  <= 1'b0;
                        lpc_ad_oe  <= 1'b1;
                        lpc_ad_out <= 4'hF;
                        state      <= ST_ABORT;
                    end else if (sync_done) begin
                        err   <= sync_err;
                        cnt   <= '0;
                        state <= cyc_write ? ST_TAREND : ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd0) begin
                        rdata_lo <= lpc_ad_in;
                    end else begin
                        if (!err) rsp_rdata <= {lpc_ad_in, rdata_lo};
                        cnt   <= '0;
                        state <= ST_TAREND;
                    end
                end
                ST_TAREND: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd1) begin
                        cnt       <= '0;
                        rsp_valid <= 1'b1;
                        rsp_error <= err;
                        state     <= ST_RESP;
                    end
                end
                ST_ABORT: begin
                    abort_cnt <= abort_cnt + 1'b1;
                    if (abort_cnt == AW'(ABORT_CLKS - 1)) begin
                        lpc_frame <= 1'b1;
                        lpc_ad_oe <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= err;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_host_io.sv
// Directed bench: drives requests, plays a scripted responder on LAD and checks bus trace and response.
module tb_lpc_host_io;
    logic        lpc_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic        lpc_frame;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in = 4'hF;

    int n_run = 0, n_fail = 0;

    // Per-cycle results gathered by run_cyc
    int          rsp_k, ntr, flo, nrsp;
    logic [63:0] trace;
    logic        got_err;
    logic [3:0]  resp_q[$];

    lpc_host_io dut (
        .lpc_clock  (lpc_clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .lpc_frame  (lpc_frame),
        .lpc_ad_out (lpc_ad_out),
        .lpc_ad_oe  (lpc_ad_oe),
        .lpc_ad_in  (lpc_ad_in)
    );

    always #5 lpc_clock = ~lpc_clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request; resp_q holds the nibbles the responder drives from the first SYNC clock on.
    task automatic run_cyc(input logic wr, input logic [15:0] addr, input logic [7:0] wd);
        int fs;
        fs = wr ? 11 : 9;
        @(negedge lpc_clock);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge lpc_clock);
        rsp_k = 0; trace = '0; ntr = 0; flo = 0; got_err = 1'b0;
        for (int k = 1; k <= 100 && rsp_k == 0; k++) begin
            @(negedge lpc_clock);
            req_valid = 1'b0;
            lpc_ad_in = (k >= fs && (k - fs) < resp_q.size()) ? resp_q[k - fs] : 4'hF;
            if (lpc_ad_oe) begin trace = {trace[59:0], lpc_ad_out}; ntr++; end
            if (!lpc_frame) flo++;
            if (rsp_valid) begin rsp_k = k; got_err = rsp_error; end
        end
        lpc_ad_in = 4'hF;
    endtask

    initial begin
        #12;
        chk("rst_frame", lpc_frame, 1);
        chk("rst_oe",    lpc_ad_oe, 0);
        chk("rst_ad",    lpc_ad_out, 4'hF);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err",   rsp_error, 0);
        @(negedge lpc_clock);
        reset = 1'b0;

        // Plain read 0x0080 returning 0x5A
        resp_q = '{4'h0, 4'hA, 4'h5};
        run_cyc(1'b0, 16'h0080, 8'h00);
        chk("rd_trace", trace, 64'h000080F);
        chk("rd_ntr",   ntr, 7);
        chk("rd_lat",   rsp_k, 14);
        chk("rd_err",   got_err, 0);
        chk("rd_data",  rsp_rdata, 8'h5A);
        chk("rd_flo",   flo, 1);
        @(negedge lpc_clock);
        chk("rsp_pulse", rsp_valid, 0);
        chk("idle_ready", req_ready, 1);

        // Write 0x03F8 <- 0xC3
        resp_q = '{4'h0};
        run_cyc(1'b1, 16'h03F8, 8'hC3);
        chk("wr_trace", trace, 64'h0203F83CF);
        chk("wr_ntr",   ntr, 9);
        chk("wr_lat",   rsp_k, 14);
        chk("wr_err",   got_err, 0);
        chk("wr_data",  rsp_rdata, 8'h5A);

        // Five long waits then ready, data 0x11
        resp_q = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h0, 4'h1, 4'h1};
        run_cyc(1'b0, 16'h0060, 8'h00);
        chk("wait_lat",  rsp_k, 19);
        chk("wait_err",  got_err, 0);
        chk("wait_data", rsp_rdata, 8'h11);

        // No responder: three 1111 SYNCs then a 4-clock abort
        resp_q = {};
        run_cyc(1'b0, 16'h1234, 8'h00);
        chk("nr_trace", trace, 64'h001234FFFFF);
        chk("nr_ntr",   ntr, 11);
        chk("nr_flo",   flo, 5);
        chk("nr_lat",   rsp_k, 16);
        chk("nr_err",   got_err, 1);

        // Error SYNC: data phase consumed, rdata kept
        resp_q = '{4'hA, 4'h7, 4'h7};
        run_cyc(1'b0, 16'h0061, 8'h00);
        chk("es_lat",  rsp_k, 14);
        chk("es_err",  got_err, 1);
        chk("es_data", rsp_rdata, 8'h11);
        chk("es_flo",  flo, 1);

        // Short wait held for 40 clocks: total-SYNC timeout at 32
        resp_q = {};
        for (int i = 0; i < 40; i++) resp_q.push_back(4'h5);
        run_cyc(1'b0, 16'h0062, 8'h00);
        chk("to_lat", rsp_k, 45);
        chk("to_err", got_err, 1);
        chk("to_flo", flo, 5);

        // Illegal SYNC code aborts at once
        resp_q = '{4'h3};
        run_cyc(1'b0, 16'h0063, 8'h00);
        chk("bad_lat",  rsp_k, 14);
        chk("bad_err",  got_err, 1);
        chk("bad_data", rsp_rdata, 8'h11);

        // Reset during ADDR releases the bus and produces no response
        @(negedge lpc_clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0070;
        @(posedge lpc_clock);
        for (int k = 1; k <= 4; k++) begin
            @(negedge lpc_clock);
            req_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("mr_frame", lpc_frame, 1);
        chk("mr_oe",    lpc_ad_oe, 0);
        @(negedge lpc_clock);
        @(negedge lpc_clock);
        reset = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge lpc_clock);
            if (rsp_valid) nrsp++;
        end
        chk("mr_norsp", nrsp, 0);
        chk("mr_ready", req_ready, 1);

        resp_q = '{4'h0, 4'hC, 4'h3};
        run_cyc(1'b0, 16'h0070, 8'h00);
        chk("mr_trace", trace, 64'h000070F);
        chk("mr_lat",   rsp_k, 14);
        chk("mr_err",   got_err, 0);
        chk("mr_data",  rsp_rdata, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
